// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch stage: FSM state encoding and default
// PC parameters used by fetch_pc_controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          DEFAULT_INC          = 4;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/adder.sv
// Plain WIDTH-bit adder shared by PC increment and redirect-target generation.
module adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/fetch_pc_controller.sv
// Fetch-stage PC owner: issues one imem request at a time, buffers the returned
// instruction toward decode and squashes in-flight fetches on redirect.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RESET | one cycle after reset release, no request
// ST_ISSUE | request at pc offered (when output register has room)
// ST_WAIT  | request accepted, waiting for the response (kill = squash)
module fetch_pc_controller
    import fetch_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int               INC          = DEFAULT_INC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_base,
    input  logic [WIDTH-1:0] redirect_offset,
    output logic             imem_req_valid,
    output logic [WIDTH-1:0] imem_req_addr,
    input  logic             imem_req_ready,
    input  logic             imem_resp_valid,
    input  logic [31:0]      imem_resp_data,
    output logic             fetch_valid,
    output logic [WIDTH-1:0] fetch_pc,
    output logic [31:0]      fetch_instr,
    output logic             misalign_err
);

    fetch_state_t     state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_inc;
    logic             kill;

    logic             redirect_active;
    logic [WIDTH-1:0] add_a;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             redirect_ok;
    logic             redirect_bad;
    logic             handshake;
    logic             deliver;
    logic [WIDTH-1:0] pc_next_seq;

    assign redirect_active = redirect_valid && (state != ST_RESET);
    assign add_a           = redirect_active ? redirect_base   : pc;
    assign add_b           = redirect_active ? redirect_offset : WIDTH'(INC);

    adder #(.WIDTH(WIDTH)) u_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (sum)
    );

    assign redirect_ok  = redirect_active &&  word_aligned(sum[1:0]);
    assign redirect_bad = redirect_active && !word_aligned(sum[1:0]);

    assign imem_req_valid = (state == ST_ISSUE) && (!fetch_valid || !stall);
    assign imem_req_addr  = pc;
    assign handshake      = imem_req_valid && imem_req_ready;

    assign deliver = (state == ST_WAIT) && imem_resp_valid && !kill && !redirect_ok;

    // A misaligned redirect in the response cycle occupies the adder, so the
    // sequential successor comes from pc_inc, captured on the last adder-free cycle.
    assign pc_next_seq = redirect_active ? pc_inc : sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= ST_RESET;
            pc           <= RESET_VECTOR;
            pc_inc       <= RESET_VECTOR;
            kill         <= 1'b0;
            fetch_valid  <= 1'b0;
            fetch_pc     <= '0;
            fetch_instr  <= '0;
            misalign_err <= 1'b0;
        end else begin
            misalign_err <= redirect_bad;

            if (!redirect_active) begin
                pc_inc <= sum;
            end

            if (redirect_ok) begin
                fetch_valid <= 1'b0;
            end else if (deliver) begin
                fetch_valid <= 1'b1;
                fetch_pc    <= pc;
                fetch_instr <= imem_resp_data;
            end else if (fetch_valid && !stall) begin
                fetch_valid <= 1'b0;
            end

            if (redirect_ok) begin
                pc <= sum;
            end else if (deliver) begin
                pc <= pc_next_seq;
            end

            case (state)
                ST_RESET: state <= ST_ISSUE;
                ST_ISSUE: begin
                    if (handshake) begin
                        state <= ST_WAIT;
                        kill  <= redirect_ok;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        state <= ST_ISSUE;
                        kill  <= 1'b0;
                    end else if (redirect_ok) begin
                        kill <= 1'b1;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: doc/fetch_pc_controller.md
# fetch_pc_controller

Owns the program counter and sequences the shared `adder` (WIDTH-bit `sum = a + b`) for both PC increment and redirect-target generation. Issues one instruction-memory request at a time over a valid/ready handshake, buffers the returned instruction in a single output register toward decode, and squashes in-flight fetches on redirect. Sits between the branch/jump resolution logic and decode in the fetch stage.

## Interface
- `WIDTH`, 32, PC/address width
- `RESET_VECTOR`, 32'h0000_0000, PC loaded on reset
- `INC`, 4, sequential PC increment in bytes

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `stall`  in  1  decode not accepting; holds output register
- `redirect_valid`  in  1  branch/jump taken this cycle
- `redirect_base`  in  WIDTH  target base (PC or rs1)
- `redirect_offset`  in  WIDTH  target immediate (sign-extended)
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_addr`  out  WIDTH  fetch address (= PC register)
- `imem_req_ready`  in  1  memory accepts request
- `imem_resp_valid`  in  1  instruction returned (one-cycle pulse)
- `imem_resp_data`  in  32  instruction word
- `fetch_valid`  out  1  output register holds an instruction
- `fetch_pc`  out  WIDTH  address of held instruction
- `fetch_instr`  out  32  held instruction
- `misalign_err`  out  1  one-cycle pulse: redirect target[1:0] != 0

## Operation
- States: RESET, ISSUE, WAIT. RESET lasts exactly one cycle, then ISSUE.
- Adder operand mux: redirect_valid (state != RESET) → a=base, b=offset; else a=pc, b=INC. Redirect has priority; one adder, one use per cycle.
- ISSUE: `imem_req_valid` = (!fetch_valid || !stall). Handshake (valid && ready) → WAIT. `resp_valid` ignored.
- WAIT: on `resp_valid` with kill=0: load output register {1, pc, data}, pc ← pc+INC, → ISSUE. With kill=1: discard response, kill ← 0, → ISSUE.
- Output register: cleared when fetch_valid && !stall, unless reloaded same edge; contents stable while stall.
- Redirect, target = base+offset mod 2^WIDTH:
  - target[1:0] != 0: `misalign_err` pulses next cycle; redirect otherwise ignored.
  - Else at next edge: pc ← target; fetch_valid ← 0 (regardless of stall).
  - ISSUE without handshake: stay ISSUE; address changes (unaccepted request retractable).
  - ISSUE with handshake same cycle: → WAIT, kill ← 1.
  - WAIT: kill ← 1. If `resp_valid` same cycle, response discarded, kill stays 0, → ISSUE.
  - Repeated redirects while WAIT: last target wins; kill stays 1.
- Arithmetic wraps mod 2^WIDTH: pc=FFFF_FFFC + 4 → 0000_0000.

## Timing
- Reset (rst_n=0 at edge): state=RESET, pc=RESET_VECTOR, kill=0, fetch_valid=0, fetch_pc=0, fetch_instr=0, misalign_err=0; `imem_req_valid`=0 in RESET.
- Reset mid-operation: outstanding request abandoned; imem shares `rst_n`, so no stale response is expected.
- First request: cycle after rst_n rises + 1 (RESET cycle), addr=RESET_VECTOR.
- Latency: `resp_valid` at edge N → fetch_valid=1 after N. Peak throughput 1 instr / 2 cycles (ready=1, response next cycle, stall=0).
- `imem_req_addr` is registered; changes only at edges.

## Structure
- Shared package/header `fetch_pkg`: state encoding (RESET, ISSUE, WAIT), default `INC`, default `RESET_VECTOR`.
- One sub-module: existing `adder` #(WIDTH), single instance fed by the operand mux. No other arithmetic instances.

## Test plan
- Reset release, ready=1, response 1 cycle after each accept, stall=0 → requests 0x0, 0x4, 0x8 on alternate cycles; fetch_pc follows 1 cycle after each response.
- stall=1 with fetch_valid=1 for 5 cycles → fetch_pc/instr constant, no new request; stall=0 → next request same cycle.
- Redirect base=0x100, offset=0x20 while WAIT → response for old PC discarded; next request 0x120; fetch_valid never shows old PC.
- Redirect base=0x100, offset=0x2 → misalign_err=1 one cycle; PC sequence unchanged.
- pc=FFFF_FFFC fetch completes → next request 0x0000_0000.
- rst_n=0 during WAIT → next cycle all outputs at reset values; first post-reset request at RESET_VECTOR.
